// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from four requesters to a single UART transmitter.
// One grant per frame; it waits for the transmitter's busy to rise and fall.
module uart_tx_arbiter #(
  parameter int BUSY_WAIT_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  REQ,
  input  logic [31:0] REQ_DATA,
  input  logic [3:0]  MASK,
  output logic [3:0]  GNT,
  output logic [7:0]  P_DATA,
  output logic        Data_Valid,
  input  logic        busy,
  output logic [1:0]  CUR_ID,
  output logic        ACTIVE,
  output logic        ERR
);

  localparam int CNT_W = (BUSY_WAIT_MAX < 1) ? 1 : $clog2(BUSY_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       eligible, gnt_n;
  logic [7:0]       pdata_n;
  logic [1:0]       cur_n, pick;
  logic             dv_n, err_n;

  // Search from last+1 upward; the smallest offset that is eligible wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] elig, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] sel;
    sel = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (elig[idx]) sel = idx;
    end
    return sel;
  endfunction

  always_comb begin
    eligible = REQ & MASK;
    pick     = rr_pick(eligible, CUR_ID);
    cnt_inc  = cnt + CNT_W'(1);
    state_n  = state;
    gnt_n    = 4'b0000;
    pdata_n  = P_DATA;
    dv_n     = 1'b0;
    cur_n    = CUR_ID;
    err_n    = 1'b0;
    cnt_n    = cnt;
    case (state)
      IDLE: begin
        if ((eligible != 4'b0000) && !busy) begin
          gnt_n   = 4'b0001 << pick;
          pdata_n = REQ_DATA[{pick, 3'b000} +: 8];
          cur_n   = pick;
          state_n = LOAD;
        end
      end
      LOAD: begin
        dv_n    = 1'b1;
        cnt_n   = '0;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy) begin
          state_n = WAIT_DONE;
        end else begin
          cnt_n = cnt_inc;
          // Transmitter never acknowledged: drop the byte, no retry.
          if (cnt_inc >= CNT_MAX) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      GNT        <= 4'b0000;
      P_DATA     <= 8'h00;
      Data_Valid <= 1'b0;
      CUR_ID     <= 2'd3;
      ACTIVE     <= 1'b0;
      ERR        <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      GNT        <= gnt_n;
      P_DATA     <= pdata_n;
      Data_Valid <= dv_n;
      CUR_ID     <= cur_n;
      ACTIVE     <= (state_n != IDLE);
      ERR        <= err_n;
      cnt        <= cnt_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single grant, round-robin, masking,
// busy timeout, busy-at-idle and mid-frame reset, with hand-computed expectations.
module tb_uart_tx_arbiter;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ;
  logic [31:0] REQ_DATA;
  logic [3:0]  MASK;
  logic [3:0]  GNT;
  logic [7:0]  P_DATA;
  logic        Data_Valid;
  logic        busy;
  logic [1:0]  CUR_ID;
  logic        ACTIVE;
  logic        ERR;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_arbiter #(.BUSY_WAIT_MAX(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .MASK(MASK),
    .GNT(GNT), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .busy(busy),
    .CUR_ID(CUR_ID), .ACTIVE(ACTIVE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full frame: wait (bounded) for a grant, then model 11 busy cycles.
  task automatic frame(input string tag, input logic [3:0] eg, input logic [7:0] ed);
    int waited   = 0;
    int dv_seen  = 0;
    int gnt_seen = 0;
    while (GNT == 4'b0000 && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_gnt"}, {28'd0, GNT}, {28'd0, eg});
    chk({tag, "_data"}, {24'd0, P_DATA}, {24'd0, ed});
    tick();
    if (Data_Valid) dv_seen++;
    if (GNT != 4'b0000) gnt_seen++;
    busy = 1'b1;
    repeat (11) begin
      tick();
      if (Data_Valid) dv_seen++;
      if (GNT != 4'b0000) gnt_seen++;
    end
    busy = 1'b0;
    tick();
    if (GNT != 4'b0000) gnt_seen++;
    chk({tag, "_dv_count"}, dv_seen, 1);
    chk({tag, "_extra_gnt"}, gnt_seen, 0);
    chk({tag, "_idle"}, {31'd0, ACTIVE}, 0);
  endtask

  initial begin
    int act_cnt;
    RST = 1'b0; REQ = 4'b0000; REQ_DATA = 32'h0; MASK = 4'hF; busy = 1'b0;
    tick(); tick();
    chk("rst_gnt", {28'd0, GNT}, 0);
    chk("rst_pdata", {24'd0, P_DATA}, 0);
    chk("rst_dv", {31'd0, Data_Valid}, 0);
    chk("rst_active", {31'd0, ACTIVE}, 0);
    chk("rst_err", {31'd0, ERR}, 0);
    chk("rst_curid", {30'd0, CUR_ID}, 3);
    RST = 1'b1;
    tick();

    // Single request from requester 1
    REQ = 4'b0010; REQ_DATA = 32'h0000A500;
    tick();
    chk("single_gnt", {28'd0, GNT}, 32'h2);
    chk("single_pdata", {24'd0, P_DATA}, 32'hA5);
    chk("single_curid", {30'd0, CUR_ID}, 1);
    chk("single_dv0", {31'd0, Data_Valid}, 0);
    REQ = 4'b0000; REQ_DATA = 32'hFFFFFFFF;
    tick();
    chk("single_dv", {31'd0, Data_Valid}, 1);
    chk("single_gnt_pulse", {28'd0, GNT}, 0);
    busy = 1'b1;
    act_cnt = 0;
    repeat (11) begin
      tick();
      if (ACTIVE) act_cnt++;
    end
    chk("single_active_busy", act_cnt, 11);
    busy = 1'b0;
    tick();
    chk("single_active_end", {31'd0, ACTIVE}, 0);
    chk("single_hold", {24'd0, P_DATA}, 32'hA5);

    // Round-robin with all four requesting, starting from reset
    RST = 1'b0;
    tick();
    REQ = 4'hF; REQ_DATA = 32'h44332211; RST = 1'b1;
    tick();
    frame("rr0", 4'b0001, 8'h11);
    frame("rr1", 4'b0010, 8'h22);
    frame("rr2", 4'b0100, 8'h33);
    frame("rr3", 4'b1000, 8'h44);
    frame("rr4", 4'b0001, 8'h11);

    // Mask excludes requesters 1 and 3
    MASK = 4'b0101;
    frame("mask0", 4'b0100, 8'h33);
    frame("mask1", 4'b0001, 8'h11);
    frame("mask2", 4'b0100, 8'h33);
    frame("mask3", 4'b0001, 8'h11);

    // Busy never rises after launch
    MASK = 4'hF; REQ = 4'b0010;
    tick();
    chk("to_gnt", {28'd0, GNT}, 32'h2);
    REQ = 4'b0000;
    tick();
    chk("to_dv", {31'd0, Data_Valid}, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("to_noerr%0d", i), {31'd0, ERR}, 0);
      chk($sformatf("to_active%0d", i), {31'd0, ACTIVE}, 1);
    end
    tick();
    chk("to_err", {31'd0, ERR}, 1);
    chk("to_idle", {31'd0, ACTIVE}, 0);
    REQ = 4'b1000;
    tick();
    chk("to_err_pulse", {31'd0, ERR}, 0);
    chk("to_next_gnt", {28'd0, GNT}, 32'h8);
    chk("to_next_data", {24'd0, P_DATA}, 32'h44);
    REQ = 4'b0000;
    tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    chk("to_next_done", {31'd0, ACTIVE}, 0);

    // Busy high while idle blocks the grant
    busy = 1'b1; REQ = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bi_nogrant%0d", i), {28'd0, GNT}, 0);
    end
    busy = 1'b0;
    tick();
    chk("bi_gnt", {28'd0, GNT}, 32'h1);
    REQ = 4'b0000;
    tick();
    chk("bi_dv", {31'd0, Data_Valid}, 1);
    busy = 1'b1;
    tick();
    tick();

    // Reset while in WAIT_DONE
    RST = 1'b0; REQ = 4'b0100;
    tick();
    chk("mr_gnt", {28'd0, GNT}, 0);
    chk("mr_pdata", {24'd0, P_DATA}, 0);
    chk("mr_dv", {31'd0, Data_Valid}, 0);
    chk("mr_active", {31'd0, ACTIVE}, 0);
    chk("mr_err", {31'd0, ERR}, 0);
    chk("mr_curid", {30'd0, CUR_ID}, 3);
    REQ = 4'b0110;
    tick();
    chk("mr_hold_gnt", {28'd0, GNT}, 0);
    RST = 1'b1; busy = 1'b0;
    tick();
    chk("mr_first_gnt", {28'd0, GNT}, 32'h2);
    chk("mr_first_data", {24'd0, P_DATA}, 32'h22);
    REQ = 4'b0000;
    tick();
    chk("mr_first_dv", {31'd0, Data_Valid}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
